serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell used by the serial adder each RUN cycle.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one bit per cycle, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        next;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  psum;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          bit_s;
    logic          bit_co;

    full_adder_cell u_fa (
        .x  (op_a[0]),
        .y  (op_b[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = RUN;
            RUN:     if (cnt == LAST) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && start) begin
            op_a  <= a;
            op_b  <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            psum  <= {bit_s, psum[N-1:1]};
            carry <= bit_co;
            cnt   <= cnt + CW'(1);
            // Last bit: publish the finished word together with its carry.
            if (cnt == LAST) begin
                sum  <= {bit_s, psum[N-1:1]};
                cout <= bit_co;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (N=8 and N=4).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int passed = 0;
    int total  = 0;
    logic [8:0] last_res8 = '0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.N(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One N=8 operation with a fixed 20-cycle observation window.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input bit repulse);
        logic [8:0] exp;
        int lat;
        int busy_cyc;
        int pulses;
        exp = 9'(a) + 9'(b) + 9'(c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1; busy_cyc = 0; pulses = 0;
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            if (busy8) busy_cyc++;
            if (done8) begin
                pulses++;
                if (lat < 0) lat = j;
            end
            if (j == 1) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            if (j == 3 && repulse) begin
                a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
            end
            if (j == 4) start8 = 1'b0;
            if (j == 4) check("run_hold", {cout8, sum8}, last_res8);
        end
        check("sum8", {cout8, sum8}, exp);
        check("lat8", lat, 8);
        check("busy8_cycles", busy_cyc, 9);
        check("done8_pulses", pulses, 1);
        last_res8 = exp;
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                          input logic c);
        int lat;
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = -1;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = j;
                break;
            end
        end
        check("sum4", {27'd0, cout4, sum4}, 32'(a) + 32'(b) + 32'(c));
        if (lat != 4) check("lat4", lat, 4);
        @(posedge clk);
    endtask

    initial begin
        int pulses;
        bit prev_done;
        bit prev_gap;
        // Reset state, checked with the clock running and rst_n low.
        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", {cout8, sum8}, 0);
        check("rst_busy4", busy4, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", busy8, 0);

        do_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op8(8'h5A, 8'h33, 1'b1, 1'b0);
        do_op8(8'h5A, 8'h33, 1'b1, 1'b1);

        // Reset during RUN drops the operation and clears the result.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        pulses = 0;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_sum", {cout8, sum8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        last_res8 = '0;
        do_op8(8'h01, 8'h01, 1'b0, 1'b0);

        // Continuously held start: back-to-back operations.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        pulses = 0; prev_done = 0; prev_gap = 0;
        for (int j = 0; j < 46; j++) begin
            @(posedge clk); #1;
            if (prev_gap) check("held_reaccept", busy8, 1);
            prev_gap = 0;
            if (prev_done) begin
                check("held_pulse_width", done8, 0);
                check("held_idle_gap", busy8, 0);
                prev_gap = 1;
            end
            prev_done = done8;
            if (done8) begin
                pulses++;
                check("held_sum", {cout8, sum8}, 9'h100);
            end
        end
        start8 = 1'b0;
        check("held_pulses", pulses >= 3, 1);
        repeat (12) @(posedge clk);
        last_res8 = 9'h100;

        for (int i = 0; i < 16; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        for (int i = 0; i < 512; i++) begin
            do_op4(4'(i), 4'(i >> 4), 1'(i >> 8));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
